// File: rtl/washer_panel.sv
// rtl/washer_panel.sv - washer front-panel key conditioning, mode/run/estop FSM and 1 Hz seconds clock

// Synchroniser, debouncer and press detector for one active-low panel key
module washer_panel_key #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic deb,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          deb_prev;
  logic [CW-1:0] cnt;

  // two-flop synchroniser, idling at the released level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  // accept a new level only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      deb <= 1'b1;
    end else if (sync2 == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      deb <= sync2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // registered one-cycle pulse on a debounced 1->0 edge; release is silent
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_prev <= 1'b1;
      press    <= 1'b0;
    end else begin
      deb_prev <= deb;
      press    <= deb_prev & ~deb;
    end
  end
endmodule

module washer_panel #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_select,
  input  logic       key_start,
  input  logic       key_emergency,
  input  logic       wash_done,
  output logic [1:0] mode,
  output logic       start,
  output logic       estop,
  output logic       sec_clk,
  output logic       sec_tick
);
  localparam int SW = $clog2(CLK_HZ);
  localparam logic [SW-1:0] SC_HALF = SW'(CLK_HZ / 2 - 1);
  localparam logic [SW-1:0] SC_LAST = SW'(CLK_HZ - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ESTOP} state_t;

  state_t        state;
  logic [SW-1:0] sc;
  logic          sel_press;
  logic          start_press;
  logic          emg_press;
  logic          emg_deb;
  logic          sel_deb_unused;
  logic          start_deb_unused;

  washer_panel_key #(.DEB_CYCLES(DEB_CYCLES)) u_key_select (
    .clk(clk), .rst(rst), .key(key_select), .deb(sel_deb_unused), .press(sel_press)
  );
  washer_panel_key #(.DEB_CYCLES(DEB_CYCLES)) u_key_start (
    .clk(clk), .rst(rst), .key(key_start), .deb(start_deb_unused), .press(start_press)
  );
  washer_panel_key #(.DEB_CYCLES(DEB_CYCLES)) u_key_emergency (
    .clk(clk), .rst(rst), .key(key_emergency), .deb(emg_deb), .press(emg_press)
  );

  // panel state machine with the seconds generator folded in so leaving RUN
  // clears sc/sec_clk/sec_tick on the same edge as the state change
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mode     <= 2'd0;
      start    <= 1'b0;
      estop    <= 1'b0;
      sec_clk  <= 1'b0;
      sec_tick <= 1'b0;
      sc       <= '0;
    end else begin
      sec_tick <= 1'b0;
      if (emg_press) begin
        state   <= S_ESTOP;
        start   <= 1'b0;
        estop   <= 1'b1;
        sec_clk <= 1'b0;
        sc      <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_press && mode != 2'd0) begin
              state   <= S_RUN;
              start   <= 1'b1;
              sec_clk <= 1'b0;
              sc      <= '0;
            end else if (sel_press) begin
              mode <= mode + 2'd1;
            end
          end
          S_RUN: begin
            if (wash_done) begin
              state   <= S_DONE;
              start   <= 1'b0;
              sec_clk <= 1'b0;
              sc      <= '0;
            end else if (start_press) begin
              state   <= S_IDLE;
              start   <= 1'b0;
              sec_clk <= 1'b0;
              sc      <= '0;
            end else if (sc == SC_LAST) begin
              sc       <= '0;
              sec_clk  <= ~sec_clk;
              sec_tick <= 1'b1;
            end else begin
              sc <= sc + 1'b1;
              if (sc == SC_HALF) begin
                sec_clk <= ~sec_clk;
              end
            end
          end
          S_DONE: begin
            if (start_press || sel_press) begin
              state <= S_IDLE;
            end
          end
          S_ESTOP: begin
            if (start_press && emg_deb) begin
              state <= S_IDLE;
              mode  <= 2'd0;
              estop <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_washer_panel.sv
// tb/tb_washer_panel.sv - directed table-driven bench for washer_panel

module tb_washer_panel;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_select = 1'b1;
  logic       key_start = 1'b1;
  logic       key_emergency = 1'b1;
  logic       wash_done = 1'b0;
  logic [1:0] mode;
  logic       start;
  logic       estop;
  logic       sec_clk;
  logic       sec_tick;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       sel;
    logic       st;
    logic       emg;
    logic       wd;
    int         edges;
    logic [1:0] mode;
    logic       start;
    logic       estop;
    logic       sclk;
    logic       stick;
  } vec_t;

  vec_t vecs[$];

  washer_panel #(.CLK_HZ(10), .DEB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .key_select(key_select), .key_start(key_start),
    .key_emergency(key_emergency), .wash_done(wash_done), .mode(mode),
    .start(start), .estop(estop), .sec_clk(sec_clk), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic add(input logic sel, st, emg, wd, input int edges,
                     input logic [1:0] m, input logic s, e, c, t);
    vec_t v;
    v.sel = sel; v.st = st; v.emg = emg; v.wd = wd; v.edges = edges;
    v.mode = m; v.start = s; v.estop = e; v.sclk = c; v.stick = t;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic sel, st, emg, wd, input int edges);
    @(negedge clk);
    key_select = sel; key_start = st; key_emergency = emg; wash_done = wd;
    repeat (edges) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [1:0] m, input logic s, e, c, t);
    logic [5:0] got;
    logic [5:0] exp;
    got = {mode, start, estop, sec_clk, sec_tick};
    exp = {m, s, e, c, t};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got{mode,start,estop,sec_clk,sec_tick}=%b expected=%b at %0t", name, got, exp, $time);
    end
  endtask

  initial begin
    // idle and select presses: mode changes 8 edges after the raw fall
    add(1, 1, 1, 0, 2, 0, 0, 0, 0, 0);
    for (int p = 1; p <= 4; p++) begin
      add(0, 1, 1, 0, 7, 2'((p - 1) % 4), 0, 0, 0, 0);
      add(0, 1, 1, 0, 1, 2'(p % 4), 0, 0, 0, 0);
      add(1, 1, 1, 0, 8, 2'(p % 4), 0, 0, 0, 0);
    end
    // bounce rejection: three 3-cycle lows, then a 10-cycle low
    for (int b = 0; b < 3; b++) begin
      add(0, 1, 1, 0, 3, 0, 0, 0, 0, 0);
      add(1, 1, 1, 0, 6, 0, 0, 0, 0, 0);
    end
    add(0, 1, 1, 0, 7, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 2, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 8, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 8, 2, 0, 0, 0, 0);
    add(1, 1, 1, 0, 8, 2, 0, 0, 0, 0);
    // run with mode 2; E is the edge start rises
    add(1, 0, 1, 0, 7, 2, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 2, 1, 0, 0, 0);
    add(1, 1, 1, 0, 4, 2, 1, 0, 0, 0);
    add(1, 1, 1, 0, 1, 2, 1, 0, 1, 0);
    add(1, 1, 1, 0, 4, 2, 1, 0, 1, 0);
    add(1, 1, 1, 0, 1, 2, 1, 0, 0, 1);
    add(1, 1, 1, 0, 1, 2, 1, 0, 0, 0);
    add(1, 1, 1, 0, 3, 2, 1, 0, 0, 0);
    add(1, 1, 1, 0, 1, 2, 1, 0, 1, 0);
    add(1, 1, 1, 0, 4, 2, 1, 0, 1, 0);
    add(1, 1, 1, 0, 1, 2, 1, 0, 0, 1);
    // wash_done ends the run; DONE holds sec_clk low
    add(1, 1, 1, 1, 1, 2, 0, 0, 0, 0);
    add(1, 1, 1, 1, 12, 2, 0, 0, 0, 0);
    // select in DONE only returns to IDLE; the next one steps mode
    add(0, 1, 1, 0, 8, 2, 0, 0, 0, 0);
    add(1, 1, 1, 0, 8, 2, 0, 0, 0, 0);
    add(0, 1, 1, 0, 8, 3, 0, 0, 0, 0);
    add(1, 1, 1, 0, 8, 3, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].st, vecs[i].emg, vecs[i].wd, vecs[i].edges);
      chk($sformatf("vec%0d", i), vecs[i].mode, vecs[i].start, vecs[i].estop,
          vecs[i].sclk, vecs[i].stick);
    end

    // emergency mid-RUN while sec_clk is high
    drive(1, 0, 1, 0, 8);  chk("emg_run_start", 3, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 8);  chk("emg_run_e8", 3, 1, 0, 1, 0);
    drive(1, 1, 0, 0, 7);  chk("emg_run_e15", 3, 1, 0, 1, 0);
    drive(1, 1, 0, 0, 1);  chk("emg_hit", 3, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 8);  chk("emg_start_held_ignored", 3, 0, 1, 0, 0);
    drive(1, 1, 0, 0, 8);  chk("emg_start_release", 3, 0, 1, 0, 0);
    drive(1, 1, 1, 0, 8);  chk("emg_released", 3, 0, 1, 0, 0);
    drive(1, 0, 1, 0, 8);  chk("emg_clear", 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 8);
    drive(1, 0, 1, 0, 8);  chk("start_mode0_ignored", 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 8);

    // simultaneous start+select, then emergency+wash_done
    drive(0, 1, 1, 0, 8);  chk("sim_mode1", 1, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 8);
    drive(0, 0, 1, 0, 8);  chk("sim_start_sel", 1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 8);  chk("sim_run_e8", 1, 1, 0, 1, 0);
    drive(1, 1, 0, 0, 7);  chk("sim_run_e15", 1, 1, 0, 1, 0);
    drive(1, 1, 0, 1, 1);  chk("sim_emg_wd", 1, 0, 1, 0, 0);
    drive(1, 1, 1, 0, 8);  chk("sim_estop_hold", 1, 0, 1, 0, 0);
    drive(1, 0, 1, 0, 8);  chk("sim_estop_clear", 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 8);

    // reset mid-RUN with key_start held low
    drive(0, 1, 1, 0, 8);
    drive(1, 1, 1, 0, 8);
    drive(1, 0, 1, 0, 8);  chk("rst_run", 1, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 6);  chk("rst_run_e6", 1, 1, 0, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_run", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 1, 0, 12); chk("rst_held_start", 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 8);  chk("rst_sel_held_start", 1, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 8);  chk("rst_release_start", 1, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 8);  chk("rst_repress_start", 1, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
